scr1_ialu_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared integer ALU (`scr1_pipe_ialu`, RVM build). It accepts operations from two independent requesters, such as the main pipe and a debug/test engine. It latches the winning operation, drives the ALU's valid/ready handshake for single- and multi-cycle (mul/div) commands, and returns a registered result to the requester that issued it.

---
 rtl/scr1_ialu_arb.sv | 154 +++++++++++++++
 tb/tb_scr1_ialu_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_ialu_arb.sv
// Two-requester round-robin front end for the shared integer ALU.
// Latches the winning operation, runs the ALU valid/ready handshake and returns a registered result.
module scr1_ialu_arb #(
  parameter int XLEN  = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_vd,
  input  logic [XLEN-1:0]  req0_op1,
  input  logic [XLEN-1:0]  req0_op2,
  input  logic [CMD_W-1:0] req0_cmd,
  output logic             req0_ack,
  output logic             req0_done,
  input  logic             req1_vd,
  input  logic [XLEN-1:0]  req1_op1,
  input  logic [XLEN-1:0]  req1_op2,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             req1_ack,
  output logic             req1_done,
  output logic [XLEN-1:0]  res,
  output logic             cmp,
  output logic             busy,
  output logic             ialu_vd,
  input  logic             ialu_rdy,
  output logic [XLEN-1:0]  ialu_op1,
  output logic [XLEN-1:0]  ialu_op2,
  output logic [CMD_W-1:0] ialu_cmd,
  input  logic [XLEN-1:0]  ialu_res,
  input  logic             ialu_cmp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant0;
  logic             grant1;
  logic             owner;
  logic             last;
  logic [XLEN-1:0]  op1_q;
  logic [XLEN-1:0]  op2_q;
  logic [CMD_W-1:0] cmd_q;
  logic [XLEN-1:0]  res_q;
  logic             cmp_q;
  logic             done0_q;
  logic             done1_q;
  logic             capture;

  // Grants are only issued from IDLE; on a tie the requester not granted last wins.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0_vd && (!req1_vd || last)) begin
          grant0 = 1'b1;
        end else if (req1_vd) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (ialu_rdy) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign capture = (state == EXEC) && ialu_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Owner and round-robin pointer move only when a grant is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 1'b0;
      last  <= 1'b1;
    end else if (grant0 || grant1) begin
      owner <= grant1;
      last  <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      cmd_q <= '0;
    end else if (grant0) begin
      op1_q <= req0_op1;
      op2_q <= req0_op2;
      cmd_q <= req0_cmd;
    end else if (grant1) begin
      op1_q <= req1_op1;
      op2_q <= req1_op2;
      cmd_q <= req1_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      cmp_q <= 1'b0;
    end else if (capture) begin
      res_q <= ialu_res;
      cmp_q <= ialu_cmp;
    end
  end

  // Done pulses line up with the single RESP cycle that follows a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= capture && !owner;
      done1_q <= capture && owner;
    end
  end

  assign req0_ack  = grant0;
  assign req1_ack  = grant1;
  assign req0_done = done0_q;
  assign req1_done = done1_q;
  assign res       = res_q;
  assign cmp       = cmp_q;
  assign busy      = (state != IDLE);
  assign ialu_vd   = (state == EXEC);
  assign ialu_op1  = op1_q;
  assign ialu_op2  = op2_q;
  assign ialu_cmd  = cmd_q;

endmodule

// File: tb/tb_scr1_ialu_arb.sv
// Directed bench for scr1_ialu_arb with a small latency-programmable ALU model.
module tb_scr1_ialu_arb;
  localparam int XLEN  = 32;
  localparam int CMD_W = 4;
  localparam logic [CMD_W-1:0] C_ADD = 4'd0;
  localparam logic [CMD_W-1:0] C_SUB = 4'd1;
  localparam logic [CMD_W-1:0] C_DIV = 4'd2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req0_vd = 1'b0;
  logic [XLEN-1:0]  req0_op1 = '0;
  logic [XLEN-1:0]  req0_op2 = '0;
  logic [CMD_W-1:0] req0_cmd = '0;
  logic             req0_ack;
  logic             req0_done;
  logic             req1_vd = 1'b0;
  logic [XLEN-1:0]  req1_op1 = '0;
  logic [XLEN-1:0]  req1_op2 = '0;
  logic [CMD_W-1:0] req1_cmd = '0;
  logic             req1_ack;
  logic             req1_done;
  logic [XLEN-1:0]  res;
  logic             cmp;
  logic             busy;
  logic             ialu_vd;
  logic             ialu_rdy;
  logic [XLEN-1:0]  ialu_op1;
  logic [XLEN-1:0]  ialu_op2;
  logic [CMD_W-1:0] ialu_cmd;
  logic [XLEN-1:0]  ialu_res;
  logic             ialu_cmp;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 0;
  int cnt      = 0;

  scr1_ialu_arb #(.XLEN(XLEN), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vd(req0_vd), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_cmd(req0_cmd),
    .req0_ack(req0_ack), .req0_done(req0_done),
    .req1_vd(req1_vd), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_cmd(req1_cmd),
    .req1_ack(req1_ack), .req1_done(req1_done),
    .res(res), .cmp(cmp), .busy(busy),
    .ialu_vd(ialu_vd), .ialu_rdy(ialu_rdy),
    .ialu_op1(ialu_op1), .ialu_op2(ialu_op2), .ialu_cmd(ialu_cmd),
    .ialu_res(ialu_res), .ialu_cmp(ialu_cmp)
  );

  always #5 clk = ~clk;

  // ALU model: result ready lat cycles after ialu_vd rises.
  always_comb begin
    ialu_res = '0;
    case (ialu_cmd)
      C_ADD:   ialu_res = ialu_op1 + ialu_op2;
      C_SUB:   ialu_res = ialu_op1 - ialu_op2;
      C_DIV:   ialu_res = (ialu_op2 != '0) ? ialu_op1 / ialu_op2 : '1;
      default: ialu_res = '0;
    endcase
    ialu_cmp = (ialu_op1 == ialu_op2);
  end

  assign ialu_rdy = ialu_vd && (cnt >= lat);

  always @(posedge clk) begin
    if (!ialu_vd) cnt <= 0;
    else          cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [XLEN-1:0] a0 [3];
  logic [XLEN-1:0] b0 [3];
  logic [XLEN-1:0] e0 [3];
  logic [XLEN-1:0] a1 [3];
  logic [XLEN-1:0] b1 [3];
  logic [XLEN-1:0] e1 [3];

  initial begin
    a0 = '{32'd1, 32'd3, 32'd5};   b0 = '{32'd2, 32'd4, 32'd6};  e0 = '{32'd3, 32'd7, 32'd11};
    a1 = '{32'd50, 32'd40, 32'd30}; b1 = '{32'd8, 32'd1, 32'd10}; e1 = '{32'd42, 32'd39, 32'd20};

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ialu_vd", 64'(ialu_vd), 64'(0));
    chk("rst_ack0", 64'(req0_ack), 64'(0));
    chk("rst_ack1", 64'(req1_ack), 64'(0));
    chk("rst_done0", 64'(req0_done), 64'(0));
    chk("rst_done1", 64'(req1_done), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_cmp", 64'(cmp), 64'(0));
    chk("rst_op1", 64'(ialu_op1), 64'(0));
    chk("rst_op2", 64'(ialu_op2), 64'(0));
    chk("rst_cmd", 64'(ialu_cmd), 64'(0));
    next();
    next();
    rst_n = 1'b1;

    // Single requester ADD 5+7
    req0_vd = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd7; req0_cmd = C_ADD;
    #1;
    chk("add_ack0_c0", 64'(req0_ack), 64'(1));
    chk("add_ack1_c0", 64'(req1_ack), 64'(0));
    chk("add_vd_c0", 64'(ialu_vd), 64'(0));
    next();
    req0_vd = 1'b0;
    #1;
    chk("add_vd_c1", 64'(ialu_vd), 64'(1));
    chk("add_busy_c1", 64'(busy), 64'(1));
    chk("add_iop1_c1", 64'(ialu_op1), 64'(5));
    chk("add_done0_c1", 64'(req0_done), 64'(0));
    next();
    chk("add_done0_c2", 64'(req0_done), 64'(1));
    chk("add_done1_c2", 64'(req1_done), 64'(0));
    chk("add_res_c2", 64'(res), 64'(12));
    chk("add_vd_c2", 64'(ialu_vd), 64'(0));
    chk("add_busy_c2", 64'(busy), 64'(1));
    next();
    chk("add_done0_c3", 64'(req0_done), 64'(0));
    chk("add_done1_c3", 64'(req1_done), 64'(0));
    chk("add_busy_c3", 64'(busy), 64'(0));

    // Tie after reset
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    req0_vd = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd20; req0_cmd = C_ADD;
    req1_vd = 1'b1; req1_op1 = 32'd9;  req1_op2 = 32'd4;  req1_cmd = C_SUB;
    #1;
    chk("tie_ack0_c0", 64'(req0_ack), 64'(1));
    chk("tie_ack1_c0", 64'(req1_ack), 64'(0));
    next();
    req0_vd = 1'b0;
    #1;
    chk("tie_ack1_c1", 64'(req1_ack), 64'(0));
    next();
    chk("tie_ack1_c2", 64'(req1_ack), 64'(0));
    chk("tie_done0_c2", 64'(req0_done), 64'(1));
    chk("tie_res_c2", 64'(res), 64'(30));
    next();
    chk("tie_ack1_c3", 64'(req1_ack), 64'(1));
    chk("tie_ack0_c3", 64'(req0_ack), 64'(0));
    next();
    req1_vd = 1'b0;
    next();
    chk("tie_done1_c5", 64'(req1_done), 64'(1));
    chk("tie_done0_c5", 64'(req0_done), 64'(0));
    chk("tie_res_c5", 64'(res), 64'(5));
    next();

    // Multi-cycle DIV from req1: 100/7
    lat = 33;
    req1_vd = 1'b1; req1_op1 = 32'd100; req1_op2 = 32'd7; req1_cmd = C_DIV;
    #1;
    chk("div_ack1", 64'(req1_ack), 64'(1));
    for (int k = 1; k <= 34; k++) begin
      next();
      req1_vd = 1'b0; req1_op1 = 32'd0; req1_op2 = 32'd0; req1_cmd = C_ADD;
      #1;
      chk("div_vd", 64'(ialu_vd), 64'(1));
      chk("div_iop1", 64'(ialu_op1), 64'(100));
      chk("div_iop2", 64'(ialu_op2), 64'(7));
      chk("div_icmd", 64'(ialu_cmd), 64'(C_DIV));
      chk("div_done1_early", 64'(req1_done), 64'(0));
      chk("div_rdy", 64'(ialu_rdy), 64'((k == 34) ? 1 : 0));
    end
    next();
    chk("div_done1", 64'(req1_done), 64'(1));
    chk("div_res", 64'(res), 64'(14));
    chk("div_vd_resp", 64'(ialu_vd), 64'(0));
    next();

    // Fairness: both requesters hold vd for six operations
    lat = 0;
    req0_vd = 1'b1; req0_op1 = a0[0]; req0_op2 = b0[0]; req0_cmd = C_ADD;
    req1_vd = 1'b1; req1_op1 = a1[0]; req1_op2 = b1[0]; req1_cmd = C_SUB;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fair_ack0", 64'(req0_ack), 64'((i % 2 == 0) ? 1 : 0));
      chk("fair_ack1", 64'(req1_ack), 64'((i % 2 == 1) ? 1 : 0));
      next();
      if (i % 2 == 0) begin
        if (i / 2 + 1 < 3) begin
          req0_op1 = a0[i / 2 + 1]; req0_op2 = b0[i / 2 + 1];
        end else begin
          req0_vd = 1'b0;
        end
      end else begin
        if (i / 2 + 1 < 3) begin
          req1_op1 = a1[i / 2 + 1]; req1_op2 = b1[i / 2 + 1];
        end else begin
          req1_vd = 1'b0;
        end
      end
      next();
      chk("fair_done0", 64'(req0_done), 64'((i % 2 == 0) ? 1 : 0));
      chk("fair_done1", 64'(req1_done), 64'((i % 2 == 1) ? 1 : 0));
      chk("fair_res", 64'(res), 64'((i % 2 == 0) ? e0[i / 2] : e1[i / 2]));
      next();
    end

    // Reset mid-EXEC of a req0 SUB
    lat = 5;
    req0_vd = 1'b1; req0_op1 = 32'd20; req0_op2 = 32'd3; req0_cmd = C_SUB;
    #1;
    chk("rx_ack0", 64'(req0_ack), 64'(1));
    next();
    req0_vd = 1'b0;
    #1;
    chk("rx_vd_exec", 64'(ialu_vd), 64'(1));
    next();
    rst_n = 1'b0;
    #1;
    chk("rx_vd_async", 64'(ialu_vd), 64'(0));
    chk("rx_busy_async", 64'(busy), 64'(0));
    chk("rx_res", 64'(res), 64'(0));
    chk("rx_iop1", 64'(ialu_op1), 64'(0));
    next();
    rst_n = 1'b1;
    lat = 0;
    #1;
    chk("rx_done0_a", 64'(req0_done), 64'(0));
    next();
    chk("rx_done0_b", 64'(req0_done), 64'(0));
    chk("rx_busy_b", 64'(busy), 64'(0));

    // Tie after mid-EXEC reset, then a late request during RESP
    req0_vd = 1'b1; req0_op1 = 32'd2; req0_op2 = 32'd2; req0_cmd = C_ADD;
    req1_vd = 1'b1; req1_op1 = 32'd6; req1_op2 = 32'd1; req1_cmd = C_ADD;
    #1;
    chk("rx_tie_ack0", 64'(req0_ack), 64'(1));
    chk("rx_tie_ack1", 64'(req1_ack), 64'(0));
    next();
    req0_vd = 1'b0;
    next();
    chk("rx_tie_done0", 64'(req0_done), 64'(1));
    chk("rx_tie_res", 64'(res), 64'(4));
    next();
    chk("late_ack1", 64'(req1_ack), 64'(1));
    next();
    req1_vd = 1'b0;
    next();
    req0_vd = 1'b1; req0_op1 = 32'd8; req0_op2 = 32'd8; req0_cmd = C_SUB;
    #1;
    chk("late_no_ack_resp", 64'(req0_ack), 64'(0));
    chk("late_done1", 64'(req1_done), 64'(1));
    chk("late_res1", 64'(res), 64'(7));
    next();
    chk("late_ack0_idle", 64'(req0_ack), 64'(1));
    next();
    req0_vd = 1'b0;
    next();
    chk("late_done0", 64'(req0_done), 64'(1));
    chk("late_res0", 64'(res), 64'(0));
    chk("late_cmp0", 64'(cmp), 64'(1));
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
